// File: rtl/sat_acc_pkg.sv
// Shared types and constants for the saturating accumulator.
// Holds the FSM state encoding, the counter width helper and the
// saturation limits expressed as functions of the data width.
package sat_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

  // Width of a counter that can hold the values 0..maxlen inclusive.
  function automatic int calc_cntw(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

  // Largest positive value of a w-bit two's-complement number (low w bits valid).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit two's-complement number, sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int w);
    return ~64'd0 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_accumulator_adder.sv
// Saturating two's-complement adder used for each accumulation step.
// Overflow is detected when both operands share a sign and the wrapped
// sum has the opposite sign; the result is then clamped to the limit
// in the direction of the operands.
// The overflow output exists only when SAT_ACC_STICKY_OVF_EN is defined.
module adder
  import sat_acc_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic [DATAW-1:0] a,
`ifdef SAT_ACC_STICKY_OVF_EN
  output logic             ovf,
`endif
  input  logic [DATAW-1:0] b,
  output logic [DATAW-1:0] sum
);

  localparam logic [DATAW-1:0] SMAX = DATAW'(sat_max(DATAW));
  localparam logic [DATAW-1:0] SMIN = DATAW'(sat_min(DATAW));

  logic [DATAW-1:0] raw;
  logic             ovf_int;

  // Wrapped add, overflow detect and clamp.
  always_comb begin
    raw     = a + b;
    ovf_int = (a[DATAW-1] == b[DATAW-1]) && (raw[DATAW-1] != a[DATAW-1]);
    sum     = raw;
    if (ovf_int) begin
      sum = a[DATAW-1] ? SMIN : SMAX;
    end
  end

`ifdef SAT_ACC_STICKY_OVF_EN
  assign ovf = ovf_int;
`endif

endmodule

// File: rtl/sat_accumulator.sv
// Sequential saturating accumulator: sums len signed beats from a
// valid/ready stream with per-step saturation and presents one
// registered result per run on a valid/ready output.
// Optional feature macro: SAT_ACC_STICKY_OVF_EN adds the sat_o port
// carrying a sticky "some step of this run saturated" flag.
module sat_accumulator
  import sat_acc_pkg::*;
#(
  parameter  int DATAW  = 32,
  parameter  int MAXLEN = 256,
  localparam int CNTW   = calc_cntw(MAXLEN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [CNTW-1:0]  len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DATAW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DATAW-1:0] out_data_o,
`ifdef SAT_ACC_STICKY_OVF_EN
  output logic             sat_o,
`endif
  output logic             busy_o
);

  localparam logic [CNTW-1:0] MAXLEN_C = CNTW'(MAXLEN);
  localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);

  acc_state_e       state_reg;
  logic [DATAW-1:0] acc_reg;
  logic [CNTW-1:0]  cnt_reg;
  logic [CNTW-1:0]  len_reg;
  logic [DATAW-1:0] out_data_reg;
  logic             out_valid_reg;

  logic             beat_fire;
  logic             run_start;
  logic [CNTW-1:0]  len_eff;
  logic             step_last;
  logic [DATAW-1:0] step_value;
  logic [DATAW-1:0] add_sum;

`ifdef SAT_ACC_STICKY_OVF_EN
  logic             add_ovf;
  logic             sticky_reg;
  logic             sat_reg;
`endif

  // A held result only blocks input while downstream is not taking it.
  assign in_ready_o  = (state_reg != HOLD) | out_ready_i;
  assign beat_fire   = in_valid_i & in_ready_o;
  // Any beat accepted outside ACC is the first beat of a new run.
  assign run_start   = (state_reg != ACC);
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign busy_o      = (state_reg == ACC);

  adder #(
    .DATAW(DATAW)
  ) u_adder (
    .a   (acc_reg),
`ifdef SAT_ACC_STICKY_OVF_EN
    .ovf (add_ovf),
`endif
    .b   (in_data_i),
    .sum (add_sum)
  );

  // Effective run length, last-beat detect and value produced by this beat.
  always_comb begin
    len_eff = len_i;
    if (len_i == '0) begin
      len_eff = ONE_C;
    end else if (len_i > MAXLEN_C) begin
      len_eff = MAXLEN_C;
    end
    if (run_start) begin
      step_last  = (len_eff == ONE_C);
      step_value = in_data_i;
    end else begin
      step_last  = (cnt_reg == (len_reg - ONE_C));
      step_value = add_sum;
    end
  end

  // FSM, accumulator, beat counter and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (clear_i) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if ((state_reg == HOLD) && out_ready_i) begin
        state_reg     <= IDLE;
        out_valid_reg <= 1'b0;
      end
      if (beat_fire) begin
        acc_reg <= step_value;
        if (run_start) begin
          len_reg <= len_eff;
        end
        if (step_last) begin
          state_reg     <= HOLD;
          out_valid_reg <= 1'b1;
          out_data_reg  <= step_value;
          cnt_reg       <= '0;
        end else begin
          state_reg <= ACC;
          cnt_reg   <= run_start ? ONE_C : (cnt_reg + ONE_C);
        end
      end
    end
  end

`ifdef SAT_ACC_STICKY_OVF_EN
  // Sticky saturation flag for the running sum, published with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_reg <= 1'b0;
      sat_reg    <= 1'b0;
    end else if (clear_i) begin
      sticky_reg <= 1'b0;
      sat_reg    <= 1'b0;
    end else if (beat_fire) begin
      if (run_start) begin
        sticky_reg <= 1'b0;
        sat_reg    <= 1'b0;
      end else if (step_last) begin
        sticky_reg <= 1'b0;
        sat_reg    <= sticky_reg | add_ovf;
      end else begin
        sticky_reg <= sticky_reg | add_ovf;
      end
    end
  end

  assign sat_o = sat_reg;
`endif

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator (DATAW=8, MAXLEN=16): the driver
// pushes the reference result of each run, a monitor pops and compares on
// every output handshake.
module tb_sat_accumulator;

  localparam int DATAW  = 8;
  localparam int MAXLEN = 16;
  localparam int CNTW   = 5;

  logic             clk;
  logic             rst_ni;
  logic             clear_i;
  logic [CNTW-1:0]  len_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DATAW-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DATAW-1:0] out_data_o;
  logic             busy_o;
`ifdef SAT_ACC_STICKY_OVF_EN
  logic             sat_o;
`endif

  typedef struct {
    int data;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   vals[$];
  int   tests  = 0;
  int   errors = 0;
  bit   rand_ready = 0;

  sat_accumulator #(
    .DATAW (DATAW),
    .MAXLEN(MAXLEN)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .len_i      (len_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
`ifdef SAT_ACC_STICKY_OVF_EN
    .sat_o      (sat_o),
`endif
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum the run with clamping to [-128,127] after every add.
  task automatic send_run(input int len);
    int eff;
    int s;
    int sat;
    int w;
    exp_t e;
    eff = (len == 0) ? 1 : ((len > MAXLEN) ? MAXLEN : len);
    s   = 0;
    sat = 0;
    for (int i = 0; i < eff; i++) begin
      if (i == 0) begin
        s = vals[i];
      end else begin
        s = s + vals[i];
        if (s > 127) begin s = 127; sat = 1; end
        if (s < -128) begin s = -128; sat = 1; end
      end
    end
    e.data = s;
    e.sat  = sat;
    exp_q.push_back(e);
    for (int i = 0; i < eff; i++) begin
      send_beat(len, vals[i], w);
    end
  endtask

  task automatic send_beat(input int len, input int data, output int waits);
    in_valid_i = 1'b1;
    len_i      = CNTW'(len);
    in_data_i  = DATAW'(data);
    waits      = 0;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      waits++;
      if (waits > 300) begin
        check("beat_accept_timeout", waits, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cycles(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: every output handshake retires the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'($signed(out_data_o)), 9999);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] out data=%0d exp=%0d", $signed(out_data_o), e.data);
          check("out_data", int'($signed(out_data_o)), e.data);
`ifdef SAT_ACC_STICKY_OVF_EN
          check("sat_o", int'(sat_o), e.sat);
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    len_i       = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
      end
    join_none

    cycles(3);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_out_data", int'(out_data_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_in_ready", int'(in_ready_o), 1);
`ifdef SAT_ACC_STICKY_OVF_EN
    check("rst_sat", int'(sat_o), 0);
`endif
    rst_ni = 1'b1;
    cycles(2);

    // 1: plain sum, latency 1 from the final beat, single-cycle valid
    exp_q.push_back('{100, 0});
    send_beat(4, 10, w);
    check("t1_busy", int'(busy_o), 1);
    send_beat(4, 20, w);
    send_beat(4, 30, w);
    send_beat(4, 40, w);
    check("t1_valid_rise", int'(out_valid_o), 1);
    check("t1_busy_done", int'(busy_o), 0);
    cycles(1);
    check("t1_valid_fall", int'(out_valid_o), 0);
    cycles(2);

    // 2: positive clamp carried on, negative clamp
    vals = {100, 100, -50};
    send_run(3);
    vals = {-100, -100};
    send_run(2);
    wait_drain();

    // 3: backpressure holds the result and stalls input
    out_ready_i = 1'b0;
    exp_q.push_back('{11, 0});
    send_beat(2, 5, w);
    send_beat(2, 6, w);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", int'(out_valid_o), 1);
      check("t3_hold_data", int'($signed(out_data_o)), 11);
      check("t3_in_ready", int'(in_ready_o), 0);
      cycles(1);
    end
    out_ready_i = 1'b1;
    cycles(1);
    check("t3_release", int'(out_valid_o), 0);

    // 4: retire and start a new run in the same cycle; len=0 acts as 1
    out_ready_i = 1'b0;
    vals = {1, 2};
    send_run(2);
    exp_q.push_back('{7, 0});
    out_ready_i = 1'b1;
    send_beat(2, 3, w);
    check("t4_no_bubble", w, 0);
    send_beat(2, 4, w);
    vals = {9};
    send_run(0);
    wait_drain();

    // 5: clear mid-run drops everything
    send_beat(4, 7, w);
    send_beat(4, 7, w);
    clear_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'd99;
    #3;
    check("t5_ready_in_clear", int'(in_ready_o), 1);
    cycles(1);
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_valid", int'(out_valid_o), 0);
      check("t5_not_busy", int'(busy_o), 0);
      cycles(1);
    end
    vals = {1};
    send_run(1);
    wait_drain();

    // 6: asynchronous reset in the middle of a run
    send_beat(4, 2, w);
    send_beat(4, 3, w);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_async_valid", int'(out_valid_o), 0);
    check("t6_async_busy", int'(busy_o), 0);
    check("t6_async_data", int'(out_data_o), 0);
    check("t6_async_ready", int'(in_ready_o), 1);
    cycles(1);
    rst_ni = 1'b1;
    cycles(1);
    vals = {2, 3};
    send_run(2);
    wait_drain();

    // Random runs with random lengths, gaps and downstream backpressure
    rand_ready = 1;
    for (int r = 0; r < 60; r++) begin
      int len;
      int eff;
      int s;
      int sat;
      exp_t e;
      len = $urandom_range(0, 20);
      eff = (len == 0) ? 1 : ((len > MAXLEN) ? MAXLEN : len);
      s   = 0;
      sat = 0;
      vals = {};
      for (int i = 0; i < eff; i++) begin
        vals.push_back(int'($urandom_range(0, 255)) - 128);
      end
      for (int i = 0; i < eff; i++) begin
        s = (i == 0) ? vals[i] : s + vals[i];
        if (s > 127) begin s = 127; if (i != 0) sat = 1; end
        if (s < -128) begin s = -128; if (i != 0) sat = 1; end
      end
      e.data = s;
      e.sat  = sat;
      exp_q.push_back(e);
      for (int i = 0; i < eff; i++) begin
        send_beat(len, vals[i], w);
        if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
      end
    end
    rand_ready = 0;
    #2;
    out_ready_i = 1'b1;
    wait_drain();
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
